tabellone_morra: RTL

TABELLONE_MORRA -- requirements
Module: tabellone_morra

---
 rtl/tabellone_morra.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tabellone_morra.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tabellone_morra                                              |
// | Brief   : Scoreboard for the morra game FSM: per-match round counters, |
// |           match tallies, last outcome and optional match history.      |
// |           Optional feature macro: TABELLONE_STORICO_EN                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tabellone_morra #(
    parameter int CNT_W  = 5,
    parameter int PART_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inizio,
    input  logic [1:0]        manche,
    input  logic [1:0]        partita,
    output logic [CNT_W-1:0]  vinte_primo,
    output logic [CNT_W-1:0]  vinte_secondo,
    output logic [CNT_W-1:0]  pareggi,
    output logic [PART_W-1:0] partite_primo,
    output logic [PART_W-1:0] partite_secondo,
    output logic [PART_W-1:0] partite_pari,
    output logic [1:0]        ultimo_esito,
    output logic              esito_valido,
    output logic [1:0]        stato_tab,
    output logic [7:0]        storico
);

    localparam logic [1:0] c_ATTESA = 2'b00;
    localparam logic [1:0] c_GIOCO  = 2'b01;
    localparam logic [1:0] c_CHIUSA = 2'b10;

    localparam logic [1:0] c_PRIMO   = 2'b01;
    localparam logic [1:0] c_SECONDO = 2'b10;
    localparam logic [1:0] c_PARI    = 2'b11;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_vinte_primo;
    logic [CNT_W-1:0]  r_vinte_secondo;
    logic [CNT_W-1:0]  r_pareggi;
    logic [PART_W-1:0] r_partite_primo;
    logic [PART_W-1:0] r_partite_secondo;
    logic [PART_W-1:0] r_partite_pari;
    logic [1:0]        r_ultimo_esito;
    logic              r_esito_valido;
    logic              w_chiude;

    // Saturating increments: counters stick at all-ones.
    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [PART_W-1:0] inc_part(input logic [PART_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_chiude = (r_state == c_GIOCO) && !inizio && (partita != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= c_ATTESA;
            r_vinte_primo     <= '0;
            r_vinte_secondo   <= '0;
            r_pareggi         <= '0;
            r_partite_primo   <= '0;
            r_partite_secondo <= '0;
            r_partite_pari    <= '0;
            r_ultimo_esito    <= 2'b00;
            r_esito_valido    <= 1'b0;
        end else begin
            r_esito_valido <= 1'b0;
            case (r_state)
                c_ATTESA: begin
                    r_vinte_primo   <= '0;
                    r_vinte_secondo <= '0;
                    r_pareggi       <= '0;
                    if (!inizio) begin
                        r_state <= c_GIOCO;
                    end
                end
                c_GIOCO: begin
                    if (inizio) begin
                        // Abort discards the match without touching the tallies.
                        r_vinte_primo   <= '0;
                        r_vinte_secondo <= '0;
                        r_pareggi       <= '0;
                        r_state         <= c_ATTESA;
                    end else begin
                        case (manche)
                            c_PRIMO:   r_vinte_primo   <= inc_cnt(r_vinte_primo);
                            c_SECONDO: r_vinte_secondo <= inc_cnt(r_vinte_secondo);
                            c_PARI:    r_pareggi       <= inc_cnt(r_pareggi);
                            default:   ;
                        endcase
                        if (w_chiude) begin
                            case (partita)
                                c_PRIMO:   r_partite_primo   <= inc_part(r_partite_primo);
                                c_SECONDO: r_partite_secondo <= inc_part(r_partite_secondo);
                                default:   r_partite_pari    <= inc_part(r_partite_pari);
                            endcase
                            r_ultimo_esito <= partita;
                            r_esito_valido <= 1'b1;
                            r_state        <= c_CHIUSA;
                        end
                    end
                end
                c_CHIUSA: begin
                    if (inizio) begin
                        r_state <= c_ATTESA;
                    end
                end
                default: begin
                    r_state <= c_ATTESA;
                end
            endcase
        end
    end

`ifdef TABELLONE_STORICO_EN
    logic [7:0] r_storico;

    // Newest outcome enters at [1:0], oldest falls out of [7:6].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_storico <= 8'd0;
        end else if (w_chiude) begin
            r_storico <= {r_storico[5:0], partita};
        end
    end

    assign storico = r_storico;
`else
    assign storico = 8'd0;
`endif

    assign vinte_primo     = r_vinte_primo;
    assign vinte_secondo   = r_vinte_secondo;
    assign pareggi         = r_pareggi;
    assign partite_primo   = r_partite_primo;
    assign partite_secondo = r_partite_secondo;
    assign partite_pari    = r_partite_pari;
    assign ultimo_esito    = r_ultimo_esito;
    assign esito_valido    = r_esito_valido;
    assign stato_tab       = r_state;

endmodule
`default_nettype wire
